// File: rtl/common_pkg.sv
// Shared pipeline types and widths: instruction payload, control bits and sizing constants.
package common;

  localparam int unsigned ROB_WIDTH      = 4;
  localparam int unsigned PRF_WIDTH      = 6;
  localparam int unsigned DISPATCH_WIDTH = 2;

  typedef struct packed {
    logic is_valid;
    logic mem_read;
    logic mem_write;
    logic reg_write;
  } control_type;

  typedef struct packed {
    control_type          control;
    logic [PRF_WIDTH-1:0] T;
    logic [PRF_WIDTH-1:0] T_old;
    logic [PRF_WIDTH-1:0] prf_rs1;
    logic [PRF_WIDTH-1:0] prf_rs2;
  } ir_is_type;

  function automatic logic is_mem_op(control_type c);
    return c.mem_read | c.mem_write;
  endfunction

endpackage

// File: rtl/dispatch_alloc.sv
// In-order prefix allocation: picks the dispatching lanes against ROB/ISQ credits and
// assigns consecutive ROB ids starting at rob_tail.
module dispatch_alloc
  import common::*;
#(
  parameter int unsigned DW     = DISPATCH_WIDTH,
  parameter int unsigned LEFT_W = 4
) (
  input  logic [DW-1:0]              pend,
  input  logic [DW-1:0]              is_mem,
  input  logic [LEFT_W-1:0]          rob_left,
  input  logic [LEFT_W-1:0]          intisq_left,
  input  logic [LEFT_W-1:0]          memisq_left,
  input  logic [ROB_WIDTH:0]         rob_tail,
  output logic [DW-1:0]              disp,
  output logic [DW-1:0][ROB_WIDTH:0] robid
);

  // Counters hold up to DW (<= 8) and must compare against any LEFT_W value.
  localparam int unsigned CW = LEFT_W + 4;

  logic [CW-1:0] n_rob, n_int, n_mem;
  logic          blocked;

  always_comb begin
    disp    = '0;
    robid   = '0;
    n_rob   = '0;
    n_int   = '0;
    n_mem   = '0;
    blocked = 1'b0;
    for (int i = 0; i < DW; i++) begin
      robid[i] = rob_tail + (ROB_WIDTH + 1)'(n_rob);
      if (pend[i] && !blocked) begin
        if ((n_rob + CW'(1) <= CW'(rob_left)) &&
            (is_mem[i] ? (n_mem + CW'(1) <= CW'(memisq_left))
                       : (n_int + CW'(1) <= CW'(intisq_left)))) begin
          disp[i] = 1'b1;
          n_rob   = n_rob + CW'(1);
          if (is_mem[i]) n_mem = n_mem + CW'(1);
          else           n_int = n_int + CW'(1);
        end else begin
          // First shortfall stops every younger lane to keep dispatch in order.
          blocked = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dispatch_nway.sv
// N-wide dispatch stage holding one renamed group; optional stall/partial counters
// are enabled with macro DISPATCH_STATS_EN.
module dispatch_nway
  import common::*;
#(
  parameter int unsigned DW     = DISPATCH_WIDTH,
  parameter int unsigned LEFT_W = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  ir_is_type [DW-1:0]            in_ir,
  input  logic [LEFT_W-1:0]             rob_left,
  input  logic [LEFT_W-1:0]             intisq_left,
  input  logic [LEFT_W-1:0]             memisq_left,
  input  logic [ROB_WIDTH:0]            rob_tail,
  output logic [DW-1:0][PRF_WIDTH-1:0]  src1_tag,
  output logic [DW-1:0][PRF_WIDTH-1:0]  src2_tag,
  input  logic [DW-1:0]                 src1_busy,
  input  logic [DW-1:0]                 src2_busy,
  output logic [DW-1:0]                 disp_valid_rob,
  output logic [DW-1:0]                 disp_valid_intisq,
  output logic [DW-1:0]                 disp_valid_memisq,
  output ir_is_type [DW-1:0]            disp_ir,
  output logic [DW-1:0][ROB_WIDTH:0]    disp_robid,
  output logic [DW-1:0]                 disp_src1_busy,
  output logic [DW-1:0]                 disp_src2_busy,
`ifdef DISPATCH_STATS_EN
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   partial_cycles,
`endif
  input  logic                          flush_valid
);

  ir_is_type [DW-1:0] grp_ir_q;
  logic [DW-1:0]      grp_pend_q;
  logic [DW-1:0]      pend_eff, is_mem, disp, load_pend;
  logic               accept;

  always_comb begin
    for (int i = 0; i < DW; i++) begin
      is_mem[i]    = is_mem_op(grp_ir_q[i].control);
      src1_tag[i]  = grp_ir_q[i].prf_rs1;
      src2_tag[i]  = grp_ir_q[i].prf_rs2;
      load_pend[i] = in_ir[i].control.is_valid;
    end
  end

  // Flush suppresses allocation entirely so no strobe can leak out that cycle.
  assign pend_eff = flush_valid ? '0 : grp_pend_q;

  dispatch_alloc #(
    .DW    (DW),
    .LEFT_W(LEFT_W)
  ) u_alloc (
    .pend       (pend_eff),
    .is_mem     (is_mem),
    .rob_left   (rob_left),
    .intisq_left(intisq_left),
    .memisq_left(memisq_left),
    .rob_tail   (rob_tail),
    .disp       (disp),
    .robid      (disp_robid)
  );

  assign disp_valid_rob    = disp;
  assign disp_valid_intisq = disp & ~is_mem;
  assign disp_valid_memisq = disp & is_mem;
  assign disp_ir           = grp_ir_q;
  assign disp_src1_busy    = src1_busy;
  assign disp_src2_busy    = src2_busy;

  assign in_ready = ~flush_valid & ~|(grp_pend_q & ~disp);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grp_pend_q <= '0;
    end else if (flush_valid) begin
      grp_pend_q <= '0;
    end else if (accept) begin
      grp_pend_q <= load_pend;
    end else begin
      grp_pend_q <= grp_pend_q & ~disp;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) grp_ir_q <= in_ir;
  end

`ifdef DISPATCH_STATS_EN
  logic stall_ev, partial_ev;
  assign stall_ev   = |grp_pend_q & ~|disp;
  assign partial_ev = |disp & |(grp_pend_q & ~disp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles   <= '0;
      partial_cycles <= '0;
    end else if (flush_valid) begin
      stall_cycles   <= '0;
      partial_cycles <= '0;
    end else begin
      if (stall_ev && (stall_cycles != '1))     stall_cycles   <= stall_cycles + 32'd1;
      if (partial_ev && (partial_cycles != '1)) partial_cycles <= partial_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_nway.sv
// Self-checking bench for dispatch_nway: directed scenarios plus randomized traffic
// compared against a lane-walking reference model.
module tb_dispatch_nway;
  import common::*;

  localparam int DW = 2;
  localparam int LW = 4;
  localparam int RW = ROB_WIDTH + 1;

  logic                         clk = 1'b0;
  logic                         reset = 1'b1;
  logic                         in_valid = 1'b0;
  logic                         in_ready;
  ir_is_type [DW-1:0]           in_ir = '0;
  logic [LW-1:0]                rob_left = '0, intisq_left = '0, memisq_left = '0;
  logic [RW-1:0]                rob_tail = '0;
  logic [DW-1:0][PRF_WIDTH-1:0] src1_tag, src2_tag;
  logic [DW-1:0]                src1_busy = '0, src2_busy = '0;
  logic [DW-1:0]                disp_valid_rob, disp_valid_intisq, disp_valid_memisq;
  ir_is_type [DW-1:0]           disp_ir;
  logic [DW-1:0][RW-1:0]        disp_robid;
  logic [DW-1:0]                disp_src1_busy, disp_src2_busy;
  logic                         flush_valid = 1'b0;
`ifdef DISPATCH_STATS_EN
  logic [31:0]                  stall_cycles, partial_cycles;
`endif

  dispatch_nway #(.DW(DW), .LEFT_W(LW)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_ir            (in_ir),
    .rob_left         (rob_left),
    .intisq_left      (intisq_left),
    .memisq_left      (memisq_left),
    .rob_tail         (rob_tail),
    .src1_tag         (src1_tag),
    .src2_tag         (src2_tag),
    .src1_busy        (src1_busy),
    .src2_busy        (src2_busy),
    .disp_valid_rob   (disp_valid_rob),
    .disp_valid_intisq(disp_valid_intisq),
    .disp_valid_memisq(disp_valid_memisq),
    .disp_ir          (disp_ir),
    .disp_robid       (disp_robid),
    .disp_src1_busy   (disp_src1_busy),
    .disp_src2_busy   (disp_src2_busy),
`ifdef DISPATCH_STATS_EN
    .stall_cycles     (stall_cycles),
    .partial_cycles   (partial_cycles),
`endif
    .flush_valid      (flush_valid)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit        m_pend[DW];
  ir_is_type m_ir[DW];
  int        m_stall, m_partial;
  bit        e_disp[DW];
  int        e_id[DW];
  bit        e_ready;
  int        n_cmp = 0, n_fail = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit lane_mem(ir_is_type r);
    return r.control.mem_read || r.control.mem_write;
  endfunction

  // Walk pending lanes oldest first, granting while every credit pool still has room.
  function automatic void model_eval();
    int ur = 0, ui = 0, um = 0;
    bit stop = 0;
    bit mem;
    e_ready = !flush_valid;
    for (int i = 0; i < DW; i++) begin
      e_disp[i] = 0;
      e_id[i]   = (int'(rob_tail) + ur) % (1 << RW);
      if (m_pend[i] && !flush_valid) begin
        mem = lane_mem(m_ir[i]);
        if (!stop && (ur + 1 <= int'(rob_left)) &&
            (mem ? (um + 1 <= int'(memisq_left)) : (ui + 1 <= int'(intisq_left)))) begin
          e_disp[i] = 1;
          ur++;
          if (mem) um++; else ui++;
        end else begin
          stop    = 1;
          e_ready = 0;
        end
      end
    end
  endfunction

  function automatic void model_clock();
    bit any_pend = 0, any_disp = 0, remain = 0;
    for (int i = 0; i < DW; i++) begin
      if (m_pend[i]) any_pend = 1;
      if (e_disp[i]) any_disp = 1;
      else if (m_pend[i]) remain = 1;
    end
    if (flush_valid) begin
      for (int i = 0; i < DW; i++) m_pend[i] = 0;
      m_stall   = 0;
      m_partial = 0;
    end else begin
      if (any_pend && !any_disp) m_stall++;
      if (any_disp && remain) m_partial++;
      if (in_valid && e_ready) begin
        for (int i = 0; i < DW; i++) begin
          m_pend[i] = in_ir[i].control.is_valid;
          m_ir[i]   = in_ir[i];
        end
      end else begin
        for (int i = 0; i < DW; i++) if (e_disp[i]) m_pend[i] = 0;
      end
    end
  endfunction

  task automatic check_outputs();
    logic [DW-1:0] ev, ei, em;
    model_eval();
    for (int i = 0; i < DW; i++) begin
      ev[i] = e_disp[i];
      ei[i] = e_disp[i] && !lane_mem(m_ir[i]);
      em[i] = e_disp[i] && lane_mem(m_ir[i]);
    end
    chk("in_ready", in_ready, e_ready);
    chk("valid_rob", disp_valid_rob, ev);
    chk("valid_intisq", disp_valid_intisq, ei);
    chk("valid_memisq", disp_valid_memisq, em);
    for (int i = 0; i < DW; i++) begin
      if (e_disp[i]) begin
        chk($sformatf("robid[%0d]", i), disp_robid[i], e_id[i]);
        chk($sformatf("disp_ir[%0d]", i), disp_ir[i], m_ir[i]);
        chk($sformatf("src1_busy[%0d]", i), disp_src1_busy[i], src1_busy[i]);
        chk($sformatf("src2_busy[%0d]", i), disp_src2_busy[i], src2_busy[i]);
      end
      if (m_pend[i]) begin
        chk($sformatf("src1_tag[%0d]", i), src1_tag[i], m_ir[i].prf_rs1);
        chk($sformatf("src2_tag[%0d]", i), src2_tag[i], m_ir[i].prf_rs2);
      end
    end
`ifdef DISPATCH_STATS_EN
    chk("stall_cycles", stall_cycles, m_stall);
    chk("partial_cycles", partial_cycles, m_partial);
`endif
  endtask

  // Inputs are set at the negedge; settle() checks mid-cycle, advance() crosses one edge.
  task automatic settle();
    src1_busy = DW'($urandom);
    src2_busy = DW'($urandom);
    #1;
    check_outputs();
  endtask

  task automatic advance();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < DW; i++) m_pend[i] = 0;
    m_stall   = 0;
    m_partial = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic ir_is_type mk(bit v, bit m);
    logic [31:0] rnd;
    ir_is_type   r;
    rnd = $urandom;
    r   = ir_is_type'(rnd[$bits(ir_is_type)-1:0]);
    r.control.is_valid  = v;
    r.control.mem_read  = m && rnd[31];
    r.control.mem_write = m && !rnd[31];
    return r;
  endfunction

  task automatic credits(int r, int i, int m);
    rob_left    = LW'(r);
    intisq_left = LW'(i);
    memisq_left = LW'(m);
  endtask

  initial begin
    do_reset();
    in_valid = 1'b0;
    settle();
    chk("reset_ready", in_ready, 1'b1);
    chk("reset_strobes", disp_valid_rob, 2'b00);
    advance();

    // {int, mem} with ample credits dispatches whole group the cycle after accept.
    credits(4, 4, 4);
    rob_tail = 5;
    in_valid = 1'b1;
    in_ir[0] = mk(1, 0);
    in_ir[1] = mk(1, 1);
    settle();
    advance();
    in_valid = 1'b0;
    settle();
    chk("t1_robid0", disp_robid[0], 5);
    chk("t1_robid1", disp_robid[1], 6);
    chk("t1_intisq", disp_valid_intisq, 2'b01);
    chk("t1_memisq", disp_valid_memisq, 2'b10);
    chk("t1_ready", in_ready, 1'b1);
    advance();

    // {mem, mem} with one mem credit splits across two cycles.
    credits(4, 4, 1);
    in_valid = 1'b1;
    in_ir[0] = mk(1, 1);
    in_ir[1] = mk(1, 1);
    settle();
    advance();
    in_valid = 1'b0;
    settle();
    chk("t2_c1_rob", disp_valid_rob, 2'b01);
    chk("t2_c1_ready", in_ready, 1'b0);
    advance();
    settle();
    chk("t2_c2_rob", disp_valid_rob, 2'b10);
    chk("t2_c2_ready", in_ready, 1'b1);
    advance();

    // {invalid, int} at rob_tail 31, followed by a back-to-back group that wraps.
    credits(4, 4, 4);
    in_valid = 1'b1;
    in_ir[0] = mk(0, 0);
    in_ir[1] = mk(1, 0);
    settle();
    advance();
    rob_tail = 31;
    in_ir[0] = mk(1, 0);
    in_ir[1] = mk(1, 0);
    settle();
    chk("t3_rob", disp_valid_rob, 2'b10);
    chk("t3_robid1", disp_robid[1], 31);
    chk("t3_ready", in_ready, 1'b1);
    advance();
    in_valid = 1'b0;
    rob_tail = 0;
    settle();
    chk("t3_wrap_id0", disp_robid[0], 0);
    chk("t3_wrap_id1", disp_robid[1], 1);
    advance();

    // Stall on zero int credits, then a one-cycle flush discards the group.
    credits(4, 0, 4);
    in_valid = 1'b1;
    in_ir[0] = mk(1, 0);
    in_ir[1] = mk(1, 0);
    settle();
    advance();
    in_valid = 1'b0;
    repeat (3) begin
      settle();
      chk("t4_stall_rob", disp_valid_rob, 2'b00);
      advance();
    end
    flush_valid = 1'b1;
    in_valid    = 1'b1;
    credits(4, 4, 4);
    settle();
    chk("t4_flush_rob", disp_valid_rob, 2'b00);
    chk("t4_flush_ready", in_ready, 1'b0);
    advance();
    flush_valid = 1'b0;
    in_valid    = 1'b0;
    settle();
    chk("t4_after_rob", disp_valid_rob, 2'b00);
    chk("t4_after_ready", in_ready, 1'b1);
    advance();

    // Asynchronous reset in the middle of a partially dispatched group.
    credits(4, 1, 4);
    in_valid = 1'b1;
    in_ir[0] = mk(1, 0);
    in_ir[1] = mk(1, 0);
    settle();
    advance();
    in_valid = 1'b0;
    settle();
    advance();
    settle();
    chk("t5_pre_rob", disp_valid_rob, 2'b10);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_async_rob", disp_valid_rob, 2'b00);
    chk("t5_async_ready", in_ready, 1'b1);
    for (int i = 0; i < DW; i++) m_pend[i] = 0;
    m_stall   = 0;
    m_partial = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      settle();
      chk("t5_post_rob", disp_valid_rob, 2'b00);
      advance();
    end

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      flush_valid = ($urandom_range(0, 19) == 0);
      credits($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      rob_tail = RW'($urandom);
      for (int i = 0; i < DW; i++) in_ir[i] = mk($urandom_range(0, 4) != 0, $urandom_range(0, 1));
      settle();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dispatch_nway.md
DISPATCH_NWAY -- requirements
Module: dispatch_nway

Interface
REQ-001 Parameter DW, default 2, number of dispatch lanes; lane 0 is oldest; legal range 1..8.
REQ-002 Parameter LEFT_W, default 4, width of each free-entry credit input.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  rename stage offers a group of DW instructions.
REQ-006 in_ready  out  1  group accepted on the edge where in_valid & in_ready.
REQ-007 in_ir  in  DW x ir_is_type  group payload: control, T, T_old, prf_rs1, prf_rs2.
REQ-008 rob_left / intisq_left / memisq_left  in  LEFT_W each  free entries in ROB, int ISQ and mem ISQ this cycle.
REQ-009 rob_tail  in  ROB_WIDTH+1  ROB id, including the phase bit, of the next ROB allocation.
REQ-010 src1_tag / src2_tag  out  DW x PRF_WIDTH  held prf_rs1 / prf_rs2 sent to the busy table.
REQ-011 src1_busy / src2_busy  in  DW  busy-table response to src*_tag in the same cycle.
REQ-012 disp_valid_rob / disp_valid_intisq / disp_valid_memisq  out  DW  per-lane dispatch strobes.
REQ-013 disp_ir  out  DW x ir_is_type; disp_robid  out  DW x (ROB_WIDTH+1); disp_src1_busy / disp_src2_busy  out  DW.
REQ-014 flush_valid  in  1  pipeline flush.

Function
REQ-015 The block holds one registered group: grp_ir[DW] and grp_pend[DW]; a lane is loaded pending iff in_ir[i].control.is_valid.
REQ-016 Latency: a group accepted at edge t is first eligible for dispatch in cycle t+1; there is no bypass from in_ir to disp_*.
REQ-017 Lane class: mem if mem_read|mem_write, otherwise int; non-pending lanes are ignored and never block younger lanes.
REQ-018 Lane i dispatches iff it is pending, all older pending lanes dispatch, and the cumulative counts through lane i satisfy rob<=rob_left, int<=intisq_left and mem<=memisq_left.
REQ-019 Partial dispatch: the dispatched lanes form an in-order prefix of the pending lanes; the lanes that dispatch clear grp_pend at the edge; the remaining lanes retry in the next cycle.
REQ-020 disp_valid_rob[i] = lane i dispatches; disp_valid_intisq[i] / disp_valid_memisq[i] = disp_valid_rob[i] qualified by the lane class.
REQ-021 disp_robid[i] = rob_tail + (number of lanes older than i that dispatch), computed modulo 2^(ROB_WIDTH+1) so the id wraps and the phase bit toggles.
REQ-022 disp_ir and disp_src*_busy are combinational pass-throughs of the held group and the busy inputs, and are meaningful only when the lane's strobe is set.
REQ-023 in_ready = ~flush_valid & (every pending lane dispatches this cycle); a new group therefore loads in the same cycle the last lane leaves, with no bubble.
REQ-024 Empty group (grp_pend==0): in_ready=1 and all strobes are 0.
REQ-025 Flush: while flush_valid is high, all strobes are 0 and in_ready is 0; at that edge grp_pend clears; an in_valid offered during flush is dropped.
REQ-026 Zero credits or any credit shortfall on the oldest pending lane: no lane dispatches and the group holds unchanged.

Reset
REQ-027 Asserting reset at any time, including mid-group, clears grp_pend immediately; from then in_ready=1 and every disp_valid_* output is 0.
REQ-028 grp_ir is don't-care after reset; the statistics counters reset to 0.

Configuration
REQ-029 With macro DISPATCH_STATS_EN defined, the block adds the outputs stall_cycles (32 bits) and partial_cycles (32 bits); both saturate at all-ones and clear on flush_valid.
REQ-030 stall_cycles increments in each cycle where grp_pend!=0 and nothing dispatches; partial_cycles increments in each cycle where at least one lane dispatches and at least one pending lane remains.
REQ-031 Without DISPATCH_STATS_EN, these ports and their counters do not exist, and all other behaviour is identical.

Structure
REQ-032 ir_is_type, control_type, ROB_WIDTH, PRF_WIDTH and a new constant DISPATCH_WIDTH (default for DW) belong in package common.
REQ-033 The prefix, credit and robid logic is one combinational sub-module, dispatch_alloc, parameterised by DW and LEFT_W.

Verification (DW=2, ROB_WIDTH=4)
REQ-034 Group {int, mem}, credits 4/4/4, rob_tail=5 -> the cycle after accept, both lanes dispatch with robid 5 and 6, valid_intisq=01, valid_memisq=10, and in_ready=1.
REQ-035 Group {mem, mem}, memisq_left=1 -> lane 0 dispatches in cycle 1; lane 1 dispatches in cycle 2 once memisq_left=1 again; in_ready is 0 in cycle 1 and 1 in cycle 2.
REQ-036 Group {invalid, int}, rob_tail=31 -> lane 1 dispatches with robid 31; the next group's lane 0 with rob_tail=0 and lane 1 get robid 0 and 1 (wrap).
REQ-037 Pending group with intisq_left=0, then flush_valid for 1 cycle -> no strobes; the group is discarded; stall_cycles (with DISPATCH_STATS_EN) counted the stall cycles, then reads 0 after the flush.
REQ-038 Reset asserted asynchronously mid-partial-group -> the strobes drop without waiting for a clock edge; after reset release in_ready=1 and the stale lane never dispatches.
